// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg
// Shared definitions for the RV32I decode stage:
//   - major opcode constants
//   - bit positions of the 38 one-hot operation strobes carried on op_o
//   - skid-buffer state enumeration
//   - packed record stored per buffered (already decoded) instruction
package riscv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int NUM_OPS = 38;

  localparam int OP_BEQ   = 0;
  localparam int OP_BNE   = 1;
  localparam int OP_BLT   = 2;
  localparam int OP_BGE   = 3;
  localparam int OP_BLTU  = 4;
  localparam int OP_BGEU  = 5;
  localparam int OP_JAL   = 6;
  localparam int OP_JALR  = 7;
  localparam int OP_LUI   = 8;
  localparam int OP_AUIPC = 9;
  localparam int OP_LB    = 10;
  localparam int OP_LH    = 11;
  localparam int OP_LW    = 12;
  localparam int OP_LBU   = 13;
  localparam int OP_LHU   = 14;
  localparam int OP_SB    = 15;
  localparam int OP_SH    = 16;
  localparam int OP_SW    = 17;
  localparam int OP_ADDI  = 18;
  localparam int OP_SLTI  = 19;
  localparam int OP_SLTIU = 20;
  localparam int OP_XORI  = 21;
  localparam int OP_ORI   = 22;
  localparam int OP_ANDI  = 23;
  localparam int OP_SLLI  = 24;
  localparam int OP_SRLI  = 25;
  localparam int OP_SRAI  = 26;
  localparam int OP_ADD   = 27;
  localparam int OP_SUB   = 28;
  localparam int OP_SLL   = 29;
  localparam int OP_SLT   = 30;
  localparam int OP_SLTU  = 31;
  localparam int OP_XOR   = 32;
  localparam int OP_SRL   = 33;
  localparam int OP_SRA   = 34;
  localparam int OP_OR    = 35;
  localparam int OP_AND   = 36;
  localparam int OP_ECALL = 37;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        imm;
    logic [NUM_OPS-1:0] op;
    logic               is_jump;
    logic               use_imm;
    logic               illegal;
  } dec_entry_t;

endpackage

// File: rtl/riscv_decode_comb.sv
// riscv_decode_comb
// Purely combinational RV32I decoder.
//   instr_i   : raw instruction word
//   op_o      : one-hot operation strobe (all-zero for unsupported encodings)
//   rs1_o/rs2_o/rd_o : register indices, zero where the format has no such field
//   imm_o     : sign-extended immediate of the format (zero-extended shamt for
//               shift-immediates, zero for R-type)
//   is_jump_o : jal or jalr
//   use_imm_o : ALU operand b comes from imm_o
//   illegal_o : unsupported encoding; only driven when RISCV_DECODE_ILLEGAL_EN
//               is defined, otherwise tied 0
// Unsupported encodings produce an all-zero record (apart from illegal_o).
module riscv_decode_comb
  import riscv_decode_pkg::*;
(
  input  logic [31:0]        instr_i,
  output logic [NUM_OPS-1:0] op_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic [31:0]        imm_o,
  output logic               is_jump_o,
  output logic               use_imm_o,
  output logic               illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  always_comb begin
    op_o      = '0;
    rs1_o     = '0;
    rs2_o     = '0;
    rd_o      = '0;
    imm_o     = '0;
    use_imm_o = 1'b0;

    case (opcode)
      OPC_LUI: begin
        op_o[OP_LUI] = 1'b1;
        rd_o = instr_i[11:7]; imm_o = imm_u; use_imm_o = 1'b1;
      end
      OPC_AUIPC: begin
        op_o[OP_AUIPC] = 1'b1;
        rd_o = instr_i[11:7]; imm_o = imm_u; use_imm_o = 1'b1;
      end
      OPC_JAL: begin
        op_o[OP_JAL] = 1'b1;
        rd_o = instr_i[11:7]; imm_o = imm_j; use_imm_o = 1'b1;
      end
      OPC_JALR: begin
        op_o[OP_JALR] = (funct3 == 3'b000);
        rd_o = instr_i[11:7]; rs1_o = instr_i[19:15]; imm_o = imm_i; use_imm_o = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: op_o[OP_BEQ]  = 1'b1;
          3'b001: op_o[OP_BNE]  = 1'b1;
          3'b100: op_o[OP_BLT]  = 1'b1;
          3'b101: op_o[OP_BGE]  = 1'b1;
          3'b110: op_o[OP_BLTU] = 1'b1;
          3'b111: op_o[OP_BGEU] = 1'b1;
          default: ;
        endcase
        // The ALU compares rs1/rs2; the B-immediate goes to the branch adder.
        rs1_o = instr_i[19:15]; rs2_o = instr_i[24:20]; imm_o = imm_b;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000: op_o[OP_LB]  = 1'b1;
          3'b001: op_o[OP_LH]  = 1'b1;
          3'b010: op_o[OP_LW]  = 1'b1;
          3'b100: op_o[OP_LBU] = 1'b1;
          3'b101: op_o[OP_LHU] = 1'b1;
          default: ;
        endcase
        rd_o = instr_i[11:7]; rs1_o = instr_i[19:15]; imm_o = imm_i; use_imm_o = 1'b1;
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: op_o[OP_SB] = 1'b1;
          3'b001: op_o[OP_SH] = 1'b1;
          3'b010: op_o[OP_SW] = 1'b1;
          default: ;
        endcase
        rs1_o = instr_i[19:15]; rs2_o = instr_i[24:20]; imm_o = imm_s; use_imm_o = 1'b1;
      end
      OPC_OPIMM: begin
        imm_o = imm_i;
        case (funct3)
          3'b000: op_o[OP_ADDI]  = 1'b1;
          3'b010: op_o[OP_SLTI]  = 1'b1;
          3'b011: op_o[OP_SLTIU] = 1'b1;
          3'b100: op_o[OP_XORI]  = 1'b1;
          3'b110: op_o[OP_ORI]   = 1'b1;
          3'b111: op_o[OP_ANDI]  = 1'b1;
          3'b001: begin
            op_o[OP_SLLI] = (funct7 == 7'b0000000);
            imm_o = imm_sh;
          end
          3'b101: begin
            // instr[30] selects arithmetic shift; other funct7 bits must be 0.
            op_o[OP_SRLI] = (funct7 == 7'b0000000);
            op_o[OP_SRAI] = (funct7 == 7'b0100000);
            imm_o = imm_sh;
          end
          default: ;
        endcase
        rd_o = instr_i[11:7]; rs1_o = instr_i[19:15]; use_imm_o = 1'b1;
      end
      OPC_OP: begin
        case ({funct7, funct3})
          10'b0000000_000: op_o[OP_ADD]  = 1'b1;
          10'b0100000_000: op_o[OP_SUB]  = 1'b1;
          10'b0000000_001: op_o[OP_SLL]  = 1'b1;
          10'b0000000_010: op_o[OP_SLT]  = 1'b1;
          10'b0000000_011: op_o[OP_SLTU] = 1'b1;
          10'b0000000_100: op_o[OP_XOR]  = 1'b1;
          10'b0000000_101: op_o[OP_SRL]  = 1'b1;
          10'b0100000_101: op_o[OP_SRA]  = 1'b1;
          10'b0000000_110: op_o[OP_OR]   = 1'b1;
          10'b0000000_111: op_o[OP_AND]  = 1'b1;
          default: ;
        endcase
        rd_o = instr_i[11:7]; rs1_o = instr_i[19:15]; rs2_o = instr_i[24:20];
      end
      OPC_SYSTEM: begin
        op_o[OP_ECALL] = (instr_i == 32'h0000_0073);
        use_imm_o = 1'b1;
      end
      default: ;
    endcase

    // Any encoding that did not select an operation yields an all-zero record.
    if (op_o == '0) begin
      rs1_o     = '0;
      rs2_o     = '0;
      rd_o      = '0;
      imm_o     = '0;
      use_imm_o = 1'b0;
    end
  end

  assign is_jump_o = op_o[OP_JAL] | op_o[OP_JALR];

`ifdef RISCV_DECODE_ILLEGAL_EN
  assign illegal_o = (op_o == '0);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
// RV32I decode stage: instructions are decoded on entry and stored in a
// 2-entry skid buffer (EMPTY/ONE/FULL) between fetch and execute.
//   clk, rst                          : clock, synchronous active-high reset
//   fetch_valid_i/fetch_ready_o       : fetch-side handshake (ready is a flop)
//   fetch_instr_i, fetch_pc_i         : offered instruction and its PC
//   flush_i                           : drop everything held and the current offer
//   dec_valid_o/dec_ready_i           : execute-side handshake
//   dec_pc_o, rs1_o, rs2_o, rd_o, imm_o, op_o, is_jump_o, use_imm_o, illegal_o
//                                     : decoded fields of the head entry
// Optional build macro: RISCV_DECODE_ILLEGAL_EN enables illegal_o reporting.
module riscv_decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid_i,
  input  logic [31:0]        fetch_instr_i,
  input  logic [XLEN-1:0]    fetch_pc_i,
  output logic               fetch_ready_o,
  input  logic               flush_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [XLEN-1:0]    dec_pc_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [NUM_OPS-1:0] op_o,
  output logic               is_jump_o,
  output logic               use_imm_o,
  output logic               illegal_o
);

  state_e     state_q, state_d;
  logic       fetch_ready_q, fetch_ready_d;
  // head_q is what execute sees; tail_q only holds data in FULL.
  dec_entry_t head_q, head_d;
  dec_entry_t tail_q, tail_d;
  dec_entry_t new_entry;
  logic       accept, consume;

  assign new_entry.pc = fetch_pc_i;

  riscv_decode_comb u_comb (
    .instr_i   (fetch_instr_i),
    .op_o      (new_entry.op),
    .rs1_o     (new_entry.rs1),
    .rs2_o     (new_entry.rs2),
    .rd_o      (new_entry.rd),
    .imm_o     (new_entry.imm),
    .is_jump_o (new_entry.is_jump),
    .use_imm_o (new_entry.use_imm),
    .illegal_o (new_entry.illegal)
  );

  assign accept  = fetch_valid_i && fetch_ready_q;
  assign consume = (state_q != ST_EMPTY) && dec_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      // Flush wins over any simultaneous accept or consume.
      state_d = ST_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b10: begin
              tail_d  = new_entry;
              state_d = ST_FULL;
            end
            2'b01: state_d = ST_EMPTY;
            2'b11: head_d  = new_entry;
            default: ;
          endcase
        end
        ST_FULL: begin
          // fetch_ready_q is low here, so only a consume can happen.
          if (consume) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Registered ready: depends on next state only, never on dec_ready_i directly.
    fetch_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      fetch_ready_q <= 1'b1;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_ready_q <= fetch_ready_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  assign fetch_ready_o = fetch_ready_q;
  assign dec_valid_o   = (state_q != ST_EMPTY);
  assign dec_pc_o      = head_q.pc;
  assign rs1_o         = head_q.rs1;
  assign rs2_o         = head_q.rs2;
  assign rd_o          = head_q.rd;
  assign imm_o         = head_q.imm;
  assign op_o          = head_q.op;
  assign is_jump_o     = head_q.is_jump;
  assign use_imm_o     = head_q.use_imm;
  assign illegal_o     = head_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage
// Self-checking bench for riscv_decode_stage. Hand-derived expected records
// are queued when the fetch handshake completes and compared when the execute
// handshake completes.
module tb_riscv_decode_stage;
  import riscv_decode_pkg::*;

  logic               clk;
  logic               rst;
  logic               fetch_valid_i;
  logic [31:0]        fetch_instr_i;
  logic [31:0]        fetch_pc_i;
  logic               fetch_ready_o;
  logic               flush_i;
  logic               dec_valid_o;
  logic               dec_ready_i;
  logic [31:0]        dec_pc_o;
  logic [4:0]         rs1_o, rs2_o, rd_o;
  logic [31:0]        imm_o;
  logic [NUM_OPS-1:0] op_o;
  logic               is_jump_o, use_imm_o, illegal_o;

  riscv_decode_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid_i (fetch_valid_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .imm_o         (imm_o),
    .op_o          (op_o),
    .is_jump_o     (is_jump_o),
    .use_imm_o     (use_imm_o),
    .illegal_o     (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    int          op_idx;   // -1 means unsupported encoding
    logic        is_jump;
    logic        use_imm;
  } exp_t;

  localparam int NVEC = 14;
  logic [31:0] vec_instr [NVEC];
  exp_t        vec_exp   [NVEC];

  exp_t        sb [$];
  exp_t        cur_exp;
  int          assertions = 0;
  int          failures   = 0;
  int          out_count  = 0;
  logic [31:0] pc_ctr     = 32'h0000_1000;

`ifdef RISCV_DECODE_ILLEGAL_EN
  localparam logic ILLEGAL_REPORTED = 1'b1;
`else
  localparam logic ILLEGAL_REPORTED = 1'b0;
`endif

  task automatic add_vec(input int i, input logic [31:0] instr, input int op_idx,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic use_imm, input logic is_jump);
    vec_instr[i]          = instr;
    vec_exp[i].pc         = '0;
    vec_exp[i].op_idx     = op_idx;
    vec_exp[i].rd         = rd;
    vec_exp[i].rs1        = rs1;
    vec_exp[i].rs2        = rs2;
    vec_exp[i].imm        = imm;
    vec_exp[i].use_imm    = use_imm;
    vec_exp[i].is_jump    = is_jump;
  endtask

  // Scoreboard monitor, sampled on the falling edge between active edges.
  always @(negedge clk) begin
    exp_t               e;
    logic [NUM_OPS-1:0] eop;
    logic               eill;
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      if (dec_valid_o && dec_ready_i) begin
        out_count++;
        if (sb.size() == 0) begin
          assertions++; failures++;
          $display("FAIL unexpected_output: got pc=%08h op=%h, required no output", dec_pc_o, op_o);
        end else begin
          e    = sb.pop_front();
          eop  = '0;
          eill = 1'b0;
          if (e.op_idx >= 0) eop[e.op_idx] = 1'b1;
          else               eill = ILLEGAL_REPORTED;
          $display("txn pc=%08h op=%h imm=%08h rd=%0d rs1=%0d rs2=%0d j=%b ui=%b ill=%b",
                   dec_pc_o, op_o, imm_o, rd_o, rs1_o, rs2_o, is_jump_o, use_imm_o, illegal_o);
          assertions++;
          if (dec_pc_o !== e.pc) begin
            failures++;
            $display("FAIL pc_order: got %08h, required %08h", dec_pc_o, e.pc);
          end
          assertions++;
          if (op_o !== eop) begin
            failures++;
            $display("FAIL op pc=%08h: got %h, required %h", e.pc, op_o, eop);
          end
          assertions++;
          if (imm_o !== e.imm) begin
            failures++;
            $display("FAIL imm pc=%08h: got %08h, required %08h", e.pc, imm_o, e.imm);
          end
          assertions++;
          if ({rd_o, rs1_o, rs2_o} !== {e.rd, e.rs1, e.rs2}) begin
            failures++;
            $display("FAIL regs pc=%08h: got rd=%0d rs1=%0d rs2=%0d, required rd=%0d rs1=%0d rs2=%0d",
                     e.pc, rd_o, rs1_o, rs2_o, e.rd, e.rs1, e.rs2);
          end
          assertions++;
          if ({is_jump_o, use_imm_o, illegal_o} !== {e.is_jump, e.use_imm, eill}) begin
            failures++;
            $display("FAIL flags pc=%08h: got j/ui/ill=%b%b%b, required %b%b%b",
                     e.pc, is_jump_o, use_imm_o, illegal_o, e.is_jump, e.use_imm, eill);
          end
        end
      end
      if (fetch_valid_i && fetch_ready_o) sb.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present vector i on the fetch port (valid stays high until wait_accept).
  task automatic prepare(input int i);
    fetch_instr_i = vec_instr[i];
    fetch_pc_i    = pc_ctr;
    cur_exp       = vec_exp[i];
    cur_exp.pc    = pc_ctr;
    pc_ctr        = pc_ctr + 32'd4;
    fetch_valid_i = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    logic taken = 1'b0;
    for (int n = 0; n < 50 && !taken; n++) begin
      taken = fetch_ready_o;
      tick();
    end
    fetch_valid_i = 1'b0;
    assertions++;
    if (!taken) begin
      failures++;
      $display("FAIL %s_accept_timeout: got fetch_ready_o=0 for 50 cycles, required acceptance", name);
    end
  endtask

  task automatic send(input int i, input string name);
    prepare(i);
    wait_accept(name);
  endtask

  task automatic drain_check(input string name);
    dec_ready_i = 1'b1;
    repeat (5) tick();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d entries still pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0050_0093;
    fetch_pc_i = 32'hdead_beef; dec_ready_i = 1'b0; flush_i = 1'b0;
    cur_exp = vec_exp[0];
    repeat (3) tick();
    assertions++;
    if ({dec_valid_o, fetch_ready_o, illegal_o, is_jump_o, use_imm_o} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_ctrl: got valid/ready/ill/j/ui=%b%b%b%b%b, required 01000",
               dec_valid_o, fetch_ready_o, illegal_o, is_jump_o, use_imm_o);
    end
    assertions++;
    if ({op_o, imm_o, dec_pc_o, rd_o, rs1_o, rs2_o} !== '0) begin
      failures++;
      $display("FAIL reset_fields: got op=%h imm=%08h pc=%08h, required all zero", op_o, imm_o, dec_pc_o);
    end
    fetch_valid_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi_latency();
    dec_ready_i = 1'b1;
    prepare(0);
    tick();
    fetch_valid_i = 1'b0;
    assertions++;
    if (dec_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL addi_latency: got dec_valid_o=%b, required 1", dec_valid_o);
    end
    drain_check("addi");
  endtask

  task automatic test_decode_table();
    dec_ready_i = 1'b1;
    for (int i = 0; i < NVEC; i++) send(i, "table");
    drain_check("table");
  endtask

  task automatic test_back_to_back();
    int          base;
    logic [31:0] first_pc;
    base = out_count;
    dec_ready_i = 1'b0;
    first_pc = pc_ctr;
    send(1, "b2b_a");
    assertions++;
    if ({dec_valid_o, fetch_ready_o} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_one: got valid/ready=%b%b, required 11", dec_valid_o, fetch_ready_o);
    end
    send(2, "b2b_b");
    assertions++;
    if ({dec_valid_o, fetch_ready_o} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_full: got valid/ready=%b%b, required 10", dec_valid_o, fetch_ready_o);
    end
    prepare(3);
    repeat (3) tick();
    assertions++;
    if (fetch_ready_o !== 1'b0 || dec_pc_o !== first_pc) begin
      failures++;
      $display("FAIL b2b_stall: got ready=%b pc=%08h, required ready=0 pc=%08h",
               fetch_ready_o, dec_pc_o, first_pc);
    end
    dec_ready_i = 1'b1;
    wait_accept("b2b_c");
    drain_check("b2b");
    assertions++;
    if (out_count - base != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d outputs, required 3", out_count - base);
    end
  endtask

  task automatic test_flush_full();
    int base;
    dec_ready_i = 1'b0;
    send(4, "flush_x");
    send(5, "flush_y");
    base = out_count;
    prepare(6);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    assertions++;
    if ({dec_valid_o, fetch_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL flush_state: got valid/ready=%b%b, required 01", dec_valid_o, fetch_ready_o);
    end
    drain_check("flush");
    assertions++;
    if (out_count != base) begin
      failures++;
      $display("FAIL flush_absent: got %0d outputs after flush, required 0", out_count - base);
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    dec_ready_i = 1'b0;
    send(7, "rst_x");
    send(8, "rst_y");
    base = out_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    assertions++;
    if ({dec_valid_o, fetch_ready_o} !== 2'b01 || op_o !== '0) begin
      failures++;
      $display("FAIL rst_mid: got valid/ready=%b%b op=%h, required 01 op=0",
               dec_valid_o, fetch_ready_o, op_o);
    end
    drain_check("rst_mid");
    assertions++;
    if (out_count != base) begin
      failures++;
      $display("FAIL rst_mid_absent: got %0d outputs, required 0", out_count - base);
    end
  endtask

  task automatic test_illegal();
    dec_ready_i = 1'b0;
    send(13, "illegal");
    assertions++;
    if (illegal_o !== ILLEGAL_REPORTED || op_o !== '0) begin
      failures++;
      $display("FAIL illegal_hold: got ill=%b op=%h, required ill=%b op=0",
               illegal_o, op_o, ILLEGAL_REPORTED);
    end
    drain_check("illegal");
  endtask

  initial begin
    //        idx instr          op        rd rs1 rs2 imm            ui j
    add_vec(0,  32'h0050_0093, OP_ADDI,  1, 0, 0, 32'd5,          1, 0);
    add_vec(1,  32'h4020_8033, OP_SUB,   0, 1, 2, 32'd0,          0, 0);
    add_vec(2,  32'h4030_D093, OP_SRAI,  1, 1, 0, 32'd3,          1, 0);
    add_vec(3,  32'hFE20_8EE3, OP_BEQ,   0, 1, 2, 32'hFFFF_FFFC,  0, 0);
    add_vec(4,  32'h0080_00EF, OP_JAL,   1, 0, 0, 32'd8,          1, 1);
    add_vec(5,  32'h1234_52B7, OP_LUI,   5, 0, 0, 32'h1234_5000,  1, 0);
    add_vec(6,  32'hFE20_AC23, OP_SW,    0, 1, 2, 32'hFFFF_FFF8,  1, 0);
    add_vec(7,  32'h0102_2183, OP_LW,    3, 4, 0, 32'd16,         1, 0);
    add_vec(8,  32'h0000_0073, OP_ECALL, 0, 0, 0, 32'd0,          1, 0);
    add_vec(9,  32'h0000_8067, OP_JALR,  0, 1, 0, 32'd0,          1, 1);
    add_vec(10, 32'h0020_F1B3, OP_AND,   3, 1, 2, 32'd0,          0, 0);
    add_vec(11, 32'h0000_1097, OP_AUIPC, 1, 0, 0, 32'h0000_1000,  1, 0);
    add_vec(12, 32'h01F0_9093, OP_SLLI,  1, 1, 0, 32'd31,         1, 0);
    add_vec(13, 32'hFFFF_FFFF, -1,       0, 0, 0, 32'd0,          0, 0);

    test_reset();
    test_addi_latency();
    test_decode_table();
    test_back_to_back();
    test_flush_full();
    test_reset_midstream();
    test_illegal();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
